// File: rtl/mem_arbiter_if.sv
// Purpose: shared types and bundled signals between the two cache requesters,
//          the memory arbiter and the downstream memory port.
// Contents:
//   mem_arbiter_pkg  - memory_operation_e (LOAD / STORE)
//   mem_arbiter_if   - requester side  : rq_valid, rq_operation, rq_address,
//                                        rq_store_word, rq_fulfilled, rq_loaded_word
//                      memory side     : mem_req_valid, mem_req_operation,
//                                        mem_req_address, mem_req_store_word,
//                                        mem_req_fulfilled, mem_loaded_word
//   modport slave    - the arbiter's view
//   modport master   - the environment's view (requesters + memory)

package mem_arbiter_pkg;
  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;
endpackage

interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) ();
  // Requester 0 = I-cache, requester 1 = D-cache.
  logic [1:0]                          rq_valid;
  mem_arbiter_pkg::memory_operation_e  rq_operation [2];
  logic [1:0][ADDR_W-1:0]              rq_address;
  logic [1:0][XLEN-1:0]                rq_store_word;
  logic [1:0]                          rq_fulfilled;
  logic [XLEN-1:0]                     rq_loaded_word;

  logic                                mem_req_valid;
  mem_arbiter_pkg::memory_operation_e  mem_req_operation;
  logic [ADDR_W-1:0]                   mem_req_address;
  logic [XLEN-1:0]                     mem_req_store_word;
  logic                                mem_req_fulfilled;
  logic [XLEN-1:0]                     mem_loaded_word;

  modport slave (
    input  rq_valid, rq_operation, rq_address, rq_store_word,
    output rq_fulfilled, rq_loaded_word,
    output mem_req_valid, mem_req_operation, mem_req_address, mem_req_store_word,
    input  mem_req_fulfilled, mem_loaded_word
  );

  modport master (
    output rq_valid, rq_operation, rq_address, rq_store_word,
    input  rq_fulfilled, rq_loaded_word,
    input  mem_req_valid, mem_req_operation, mem_req_address, mem_req_store_word,
    output mem_req_fulfilled, mem_loaded_word
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: two-requester memory arbiter (I-cache / D-cache) in front of a
//          single memory port. Ownership is held for a whole line transaction
//          (as long as the owner keeps rq_valid high), ties from idle go to the
//          requester named by a round-robin priority pointer, and ownership
//          hands over directly to a waiting requester without an idle bubble.
// Ports:
//   clk              - clock, all state on posedge
//   reset_n          - synchronous active-low reset
//   bus              - mem_arbiter_if.slave (requester + memory signals)
//   grant[1:0]       - one-hot current owner, 2'b00 when idle
//   grant_count0/1   - saturating count of grants given to each requester
//   conflict_cycles  - saturating count of cycles where a valid requester
//                      was not the owner
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | no owner; memory request outputs held at zero
// ST_GRANT0 | requester 0 (I-cache) owns the memory port
// ST_GRANT1 | requester 1 (D-cache) owns the memory port

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_arbiter_if.slave     bus,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] grant_count0,
  output logic [CNT_W-1:0] grant_count1,
  output logic [CNT_W-1:0] conflict_cycles
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] gcnt0_q, gcnt0_d;
  logic [CNT_W-1:0] gcnt1_q, gcnt1_d;
  logic [CNT_W-1:0] conf_q, conf_d;

  logic [1:0]       rv;
  logic             enter0, enter1, conflict;
  logic [1:0]       state_eff;

  logic                               req_valid;
  mem_arbiter_pkg::memory_operation_e req_op;
  logic [ADDR_W-1:0]                  req_addr;
  logic [XLEN-1:0]                    req_data;

  assign rv = bus.rq_valid;

  // Next-state and priority pointer
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        case (rv)
          2'b01:   state_d = ST_GRANT0;
          2'b10:   state_d = ST_GRANT1;
          2'b11:   state_d = prio_q ? ST_GRANT1 : ST_GRANT0;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_GRANT0: begin
        if (!rv[0]) begin
          prio_d  = 1'b1;
          state_d = rv[1] ? ST_GRANT1 : ST_IDLE;
        end
      end
      ST_GRANT1: begin
        if (!rv[1]) begin
          prio_d  = 1'b0;
          state_d = rv[0] ? ST_GRANT0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Statistics: a grant is counted on entry, a conflict cycle is any cycle
  // where at least one valid requester is not the current owner.
  always_comb begin
    enter0   = (state_d == ST_GRANT0) && (state_q != ST_GRANT0);
    enter1   = (state_d == ST_GRANT1) && (state_q != ST_GRANT1);
    conflict = (rv[0] && (state_q != ST_GRANT0)) ||
               (rv[1] && (state_q != ST_GRANT1));

    gcnt0_d = gcnt0_q;
    gcnt1_d = gcnt1_q;
    conf_d  = conf_q;
    if (enter0 && (gcnt0_q != CNT_MAX))  gcnt0_d = gcnt0_q + CNT_ONE;
    if (enter1 && (gcnt1_q != CNT_MAX))  gcnt1_d = gcnt1_q + CNT_ONE;
    if (conflict && (conf_q != CNT_MAX)) conf_d  = conf_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      conf_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
      conf_q  <= conf_d;
    end
  end

  // Outputs decode from the state, forced to idle while reset is held so that
  // nothing leaks out during the reset cycle itself.
  assign state_eff = reset_n ? state_q : ST_IDLE;

  always_comb begin
    req_valid = 1'b0;
    req_op    = mem_arbiter_pkg::LOAD;
    req_addr  = '0;
    req_data  = '0;
    if (state_eff == ST_GRANT0) begin
      req_valid = rv[0];
      req_op    = bus.rq_operation[0];
      req_addr  = bus.rq_address[0];
      req_data  = bus.rq_store_word[0];
    end else if (state_eff == ST_GRANT1) begin
      req_valid = rv[1];
      req_op    = bus.rq_operation[1];
      req_addr  = bus.rq_address[1];
      req_data  = bus.rq_store_word[1];
    end
  end

  assign grant                  = {state_eff == ST_GRANT1, state_eff == ST_GRANT0};
  assign bus.mem_req_valid      = req_valid;
  assign bus.mem_req_operation  = req_op;
  assign bus.mem_req_address    = req_addr;
  assign bus.mem_req_store_word = req_data;
  assign bus.rq_fulfilled       = {2{bus.mem_req_fulfilled}} & grant;
  assign bus.rq_loaded_word     = bus.mem_loaded_word;

  assign grant_count0    = gcnt0_q;
  assign grant_count1    = gcnt1_q;
  assign conflict_cycles = conf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter. Directed scenarios plus a
//          randomized run checked against an owner/priority reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int XLEN   = 32;
  localparam int CNT_W  = 16;
  localparam int CMAX   = 65535;

  logic             clk;
  logic             reset_n;
  logic [1:0]       grant;
  logic [CNT_W-1:0] grant_count0, grant_count1, conflict_cycles;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus.slave),
    .grant           (grant),
    .grant_count0    (grant_count0),
    .grant_count1    (grant_count1),
    .conflict_cycles (conflict_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int chk;
  int errs;

  // Reference model: owner is -1 (nobody), 0 or 1.
  int m_owner;
  int m_prio;
  int m_gc[2];
  int m_conf;

  logic [1:0]        e_grant, e_ful;
  logic              e_mval;
  memory_operation_e e_op;
  logic [ADDR_W-1:0] e_addr;
  logic [XLEN-1:0]   e_data;

  function automatic void model_tick();
    logic [1:0] rv;
    bit         waiting;
    int         nxt;
    rv = bus.rq_valid;
    if (!reset_n) begin
      m_owner = -1; m_prio = 0; m_gc[0] = 0; m_gc[1] = 0; m_conf = 0;
      return;
    end
    waiting = 0;
    for (int j = 0; j < 2; j++) if (rv[j] && m_owner != j) waiting = 1;
    if (waiting && m_conf < CMAX) m_conf++;
    nxt = m_owner;
    if (m_owner < 0) begin
      if (rv == 2'b11)  nxt = m_prio;
      else if (rv[0])   nxt = 0;
      else if (rv[1])   nxt = 1;
    end else if (!rv[m_owner]) begin
      m_prio = 1 - m_owner;
      nxt    = rv[1 - m_owner] ? 1 - m_owner : -1;
    end
    if (nxt >= 0 && nxt != m_owner && m_gc[nxt] < CMAX) m_gc[nxt]++;
    m_owner = nxt;
  endfunction

  function automatic void model_outputs();
    int o;
    o = reset_n ? m_owner : -1;
    e_grant = 2'b00; e_mval = 1'b0; e_op = LOAD; e_addr = '0; e_data = '0;
    if (o >= 0) begin
      e_grant = (o == 0) ? 2'b01 : 2'b10;
      e_mval  = bus.rq_valid[o];
      e_op    = bus.rq_operation[o];
      e_addr  = bus.rq_address[o];
      e_data  = bus.rq_store_word[o];
    end
    e_ful = bus.mem_req_fulfilled ? e_grant : 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.rq_valid = 2'b00;
    bus.mem_req_fulfilled = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] lw;
    reset_n = 1'b0;
    bus.rq_valid = 2'b11;
    bus.mem_req_fulfilled = 1'b1;
    lw = XLEN'($urandom);
    bus.mem_loaded_word = lw;
    tick(); tick();
    #1;
    chk++; if (grant !== 2'b00) begin errs++; $display("FAIL rst_grant got=%b exp=00", grant); end
    chk++; if (bus.mem_req_valid !== 1'b0) begin errs++; $display("FAIL rst_mval got=%b exp=0", bus.mem_req_valid); end
    chk++; if (bus.rq_fulfilled !== 2'b00) begin errs++; $display("FAIL rst_ful got=%b exp=00", bus.rq_fulfilled); end
    chk++; if ({grant_count0, grant_count1, conflict_cycles} !== '0) begin errs++;
      $display("FAIL rst_counters got=%h/%h/%h exp=0", grant_count0, grant_count1, conflict_cycles); end
    chk++; if (bus.rq_loaded_word !== lw) begin errs++; $display("FAIL loaded_passthru got=%h exp=%h", bus.rq_loaded_word, lw); end
    bus.rq_valid = 2'b00;
    bus.mem_req_fulfilled = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.rq_valid = 2'b11;
    #1;
    chk++; if (grant !== 2'b00 || bus.mem_req_valid !== 1'b0) begin errs++;
      $display("FAIL sim_first_cycle got=%b/%b exp=00/0", grant, bus.mem_req_valid); end
    tick(); #1;
    chk++; if (grant !== 2'b01) begin errs++; $display("FAIL sim_grant0 got=%b exp=01", grant); end
    chk++; if (bus.mem_req_valid !== 1'b1) begin errs++; $display("FAIL sim_mval got=%b exp=1", bus.mem_req_valid); end
    chk++; if (bus.mem_req_address !== bus.rq_address[0]) begin errs++;
      $display("FAIL sim_addr0 got=%h exp=%h", bus.mem_req_address, bus.rq_address[0]); end
    bus.rq_valid = 2'b10;
    tick(); #1;
    chk++; if (grant !== 2'b10) begin errs++; $display("FAIL sim_handover got=%b exp=10", grant); end
    chk++; if (bus.mem_req_address !== bus.rq_address[1] || bus.mem_req_store_word !== bus.rq_store_word[1]) begin errs++;
      $display("FAIL sim_addr1 got=%h/%h exp=%h/%h", bus.mem_req_address, bus.mem_req_store_word,
               bus.rq_address[1], bus.rq_store_word[1]); end
    chk++; if (grant_count0 !== 16'd1 || grant_count1 !== 16'd1) begin errs++;
      $display("FAIL sim_gcounts got=%0d/%0d exp=1/1", grant_count0, grant_count1); end
    bus.rq_valid = 2'b00;
    tick();
  endtask

  task automatic test_fill();
    int n;
    do_reset();
    bus.rq_valid = 2'b10;
    tick();
    n = 0;
    for (int k = 0; k < 7; k++) begin
      bus.mem_req_fulfilled = (k % 2 == 0);
      if (k == 6) bus.rq_valid = 2'b00;
      #1;
      if (bus.rq_fulfilled == 2'b10) n++;
      chk++; if (bus.rq_fulfilled[0] !== 1'b0 || grant !== 2'b10) begin errs++;
        $display("FAIL fill_owner k=%0d got=%b/%b exp=10", k, grant, bus.rq_fulfilled); end
      tick();
    end
    #1;
    chk++; if (n != 4) begin errs++; $display("FAIL fill_beats got=%0d exp=4", n); end
    chk++; if (grant !== 2'b00) begin errs++; $display("FAIL fill_release got=%b exp=00", grant); end
    chk++; if (bus.rq_fulfilled !== 2'b00) begin errs++; $display("FAIL idle_ful_ignored got=%b exp=00", bus.rq_fulfilled); end
    chk++; if (grant_count1 !== 16'd1 || grant_count0 !== 16'd0) begin errs++;
      $display("FAIL fill_gcounts got=%0d/%0d exp=0/1", grant_count0, grant_count1); end
    bus.mem_req_fulfilled = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    bus.rq_valid = 2'b11;
    tick();
    for (int k = 0; k < 8; k++) begin
      bus.mem_req_fulfilled = (k % 2 == 0);
      #1;
      chk++; if (grant !== 2'b01 || bus.rq_fulfilled[1] !== 1'b0) begin errs++;
        $display("FAIL hold_grant k=%0d got=%b exp=01", k, grant); end
      chk++; if (conflict_cycles !== CNT_W'(k + 1)) begin errs++;
        $display("FAIL hold_conflict k=%0d got=%0d exp=%0d", k, conflict_cycles, k + 1); end
      tick();
    end
    bus.mem_req_fulfilled = 1'b0;
    bus.rq_valid = 2'b10;
    tick();
    bus.rq_valid = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    int seq[3];
    seq = '{0, 1, 0};
    do_reset();
    bus.rq_valid = 2'b11;
    tick();
    for (int r = 0; r < 3; r++) begin
      #1;
      chk++; if (grant !== ((seq[r] == 0) ? 2'b01 : 2'b10)) begin errs++;
        $display("FAIL b2b_round%0d got=%b exp_owner=%0d", r, grant, seq[r]); end
      if (r == 2) bus.rq_valid = 2'b00;
      else        bus.rq_valid = (seq[r] == 0) ? 2'b10 : 2'b01;
      tick();
      if (r < 2) bus.rq_valid = 2'b11;
    end
    #1;
    chk++; if (grant !== 2'b00) begin errs++; $display("FAIL b2b_idle got=%b exp=00", grant); end
    bus.rq_valid = 2'b11;
    tick(); #1;
    chk++; if (grant !== 2'b10) begin errs++; $display("FAIL b2b_prio got=%b exp=10", grant); end
    chk++; if (grant_count0 !== 16'd2 || grant_count1 !== 16'd2) begin errs++;
      $display("FAIL b2b_gcounts got=%0d/%0d exp=2/2", grant_count0, grant_count1); end
    bus.rq_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.rq_valid = 2'b10;
    tick();
    bus.mem_req_fulfilled = 1'b1;
    #1;
    chk++; if (bus.rq_fulfilled !== 2'b10) begin errs++; $display("FAIL mid_beat got=%b exp=10", bus.rq_fulfilled); end
    reset_n = 1'b0;
    tick(); #1;
    chk++; if (grant !== 2'b00 || bus.mem_req_valid !== 1'b0 || bus.rq_fulfilled !== 2'b00) begin errs++;
      $display("FAIL mid_rst_out got=%b/%b/%b exp=00/0/00", grant, bus.mem_req_valid, bus.rq_fulfilled); end
    chk++; if ({grant_count0, grant_count1, conflict_cycles} !== '0) begin errs++;
      $display("FAIL mid_rst_counters got=%h/%h/%h exp=0", grant_count0, grant_count1, conflict_cycles); end
    reset_n = 1'b1;
    #1;
    chk++; if (bus.rq_fulfilled !== 2'b00) begin errs++; $display("FAIL mid_after_rst got=%b exp=00", bus.rq_fulfilled); end
    bus.mem_req_fulfilled = 1'b0;
    bus.rq_valid = 2'b00;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) bus.rq_valid[0] = ~bus.rq_valid[0];
      if ($urandom_range(0, 3) == 0) bus.rq_valid[1] = ~bus.rq_valid[1];
      for (int i = 0; i < 2; i++) begin
        bus.rq_operation[i]  = memory_operation_e'($urandom_range(0, 1));
        bus.rq_address[i]    = ADDR_W'($urandom);
        bus.rq_store_word[i] = XLEN'($urandom);
      end
      bus.mem_req_fulfilled = 1'($urandom_range(0, 1));
      bus.mem_loaded_word   = XLEN'($urandom);
      reset_n = ($urandom_range(0, 99) != 0);
      #1;
      model_outputs();
      chk++; if (grant !== e_grant) begin errs++; $display("FAIL rnd_grant n=%0d got=%b exp=%b", n, grant, e_grant); end
      chk++; if (bus.mem_req_valid !== e_mval || bus.mem_req_operation !== e_op) begin errs++;
        $display("FAIL rnd_req n=%0d got=%b/%0d exp=%b/%0d", n, bus.mem_req_valid, bus.mem_req_operation, e_mval, e_op); end
      chk++; if (bus.mem_req_address !== e_addr || bus.mem_req_store_word !== e_data) begin errs++;
        $display("FAIL rnd_bus n=%0d got=%h/%h exp=%h/%h", n, bus.mem_req_address, bus.mem_req_store_word, e_addr, e_data); end
      chk++; if (bus.rq_fulfilled !== e_ful || bus.rq_loaded_word !== bus.mem_loaded_word) begin errs++;
        $display("FAIL rnd_ful n=%0d got=%b exp=%b", n, bus.rq_fulfilled, e_ful); end
      chk++; if (grant_count0 !== CNT_W'(m_gc[0]) || grant_count1 !== CNT_W'(m_gc[1]) || conflict_cycles !== CNT_W'(m_conf)) begin errs++;
        $display("FAIL rnd_counters n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, grant_count0, grant_count1,
                 conflict_cycles, m_gc[0], m_gc[1], m_conf); end
      tick();
    end
    reset_n = 1'b1;
    bus.rq_valid = 2'b00;
    bus.mem_req_fulfilled = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    bus.rq_valid = 2'b11;
    tick();
    repeat (65533) tick();
    #1;
    chk++; if (conflict_cycles !== 16'hFFFE) begin errs++; $display("FAIL sat_preload got=%h exp=fffe", conflict_cycles); end
    tick(); #1;
    chk++; if (conflict_cycles !== 16'hFFFF) begin errs++; $display("FAIL sat_reach got=%h exp=ffff", conflict_cycles); end
    repeat (5) tick();
    #1;
    chk++; if (conflict_cycles !== 16'hFFFF || CNT_W'(m_conf) !== conflict_cycles) begin errs++;
      $display("FAIL sat_hold got=%h exp=ffff", conflict_cycles); end
    chk++; if (grant !== 2'b01 || grant_count0 !== 16'd1) begin errs++;
      $display("FAIL sat_grant got=%b/%0d exp=01/1", grant, grant_count0); end
    bus.rq_valid = 2'b00;
    tick();
  endtask

  initial begin
    chk = 0; errs = 0;
    m_owner = -1; m_prio = 0; m_gc[0] = 0; m_gc[1] = 0; m_conf = 0;
    reset_n = 1'b0;
    bus.rq_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      bus.rq_operation[i]  = (i == 0) ? LOAD : STORE;
      bus.rq_address[i]    = ADDR_W'($urandom);
      bus.rq_store_word[i] = XLEN'($urandom);
    end
    bus.mem_req_fulfilled = 1'b0;
    bus.mem_loaded_word   = '0;

    test_reset();
    test_simultaneous();
    test_fill();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturation();

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of the block address and word address.
REQ-002 Parameter XLEN, default 32, width of the data word.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 rq_valid[1:0]  input  2  per-requester request valid (0 = I-cache, 1 = D-cache); held high for the whole line transaction.
REQ-007 rq_operation[i]  input  memory_operation_e  LOAD or STORE, per requester.
REQ-008 rq_address[i], rq_store_word[i]  input  ADDR_W / XLEN  per-requester address and store data.
REQ-009 rq_fulfilled[1:0], rq_loaded_word  output  2 / XLEN  per-requester beat-done strobe; shared load data.
REQ-010 mem_req_valid, mem_req_operation, mem_req_address, mem_req_store_word  output  1 / enum / ADDR_W / XLEN  downstream request.
REQ-011 mem_req_fulfilled, mem_loaded_word  input  1 / XLEN  downstream beat completion and load data.
REQ-012 grant[1:0]  output  2  one-hot current owner; 2'b00 when idle.
REQ-013 grant_count0, grant_count1, conflict_cycles  output  CNT_W each  statistics counters.

Function
REQ-014 FSM states: ST_IDLE, ST_GRANT0, ST_GRANT1; state is registered; grant decodes the state (GRANT0 -> 2'b01, GRANT1 -> 2'b10).
REQ-015 A 1-bit priority pointer prio names the requester favoured on a tie.
REQ-016 ST_IDLE: if exactly one rq_valid is high, enter that requester's GRANT state; if both are high, enter GRANT[prio]; if neither, stay.
REQ-017 ST_GRANTi: while rq_valid[i] is high, stay.
REQ-018 ST_GRANTi with rq_valid[i] low: if rq_valid[1-i] is high, go directly to GRANT(1-i) with no idle bubble; otherwise go to ST_IDLE.
REQ-019 On every exit from ST_GRANTi, set prio to 1-i.
REQ-020 Grant latency from ST_IDLE is one cycle; mem_req_valid is never asserted in the cycle a request first arrives.
REQ-021 In ST_GRANTi, mem_req_valid = rq_valid[i], and mem_req_operation/address/store_word are taken combinationally from requester i.
REQ-022 In ST_IDLE: mem_req_valid = 0, mem_req_operation = LOAD, and address/data outputs = 0.
REQ-023 rq_fulfilled[i] = mem_req_fulfilled & grant[i]; the non-granted requester never sees fulfilled.
REQ-024 rq_loaded_word = mem_loaded_word, unconditionally.
REQ-025 A mem_req_fulfilled arriving in ST_IDLE is ignored and produces no rq_fulfilled.
REQ-026 The grant never changes while the owner's rq_valid is high, so a multi-beat line fill or writeback is never split.
REQ-027 A requester dropping rq_valid in the same cycle as its final fulfilled beat releases the grant at the next edge.
REQ-028 grant_count_i increments by 1 on each entry into ST_GRANTi.
REQ-029 conflict_cycles increments by 1 in each cycle where some rq_valid[j] is high and the state is not ST_GRANTj.
REQ-030 All counters saturate at all-ones and never wrap.

Reset
REQ-031 When reset_n = 0 at a clock edge, the block takes: state = ST_IDLE, prio = 0, all counters = 0.
REQ-032 While in reset: grant = 0, mem_req_valid = 0, rq_fulfilled = 0.
REQ-033 Reset asserted mid-transaction abandons the grant immediately; no rq_fulfilled is produced after that edge.

Verification
REQ-034 Both rq_valid rise together after reset -> cycle+1 grant = 01, mem_req_valid = 1, mem address = rq_address[0]; after rq_valid[0] drops -> next cycle grant = 10 with no idle cycle.
REQ-035 Requester 1 alone does a 4-beat fill (4 mem_req_fulfilled pulses) -> rq_fulfilled = 2'b10 exactly 4 times; grant_count1 = 1.
REQ-036 Requester 0 holds a 4-beat grant while requester 1 waits -> grant stays 01 throughout; conflict_cycles advances once per waiting cycle.
REQ-037 Back-to-back contention for 3 rounds -> grants alternate 0,1,0; prio toggles on each exit.
REQ-038 reset_n pulled low during a GRANT1 beat -> next cycle grant = 0, mem_req_valid = 0, all counters = 0.
REQ-039 Preload conflict_cycles to 16'hFFFE via contention -> counter reaches 16'hFFFF and holds.
